// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-word reads and buffers them in a prefetch queue.
// Define FETCH_BYPASS_EN to forward a returning word straight to ir when the queue is empty.
module fetch_unit #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int RESET_PC = 32,
  parameter int DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_accept,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  slot_data_q [DEPTH];
  logic [ADDR_W-1:0]  slot_pc_q   [DEPTH];

  logic complete, head_valid, bypass_vld, bypass_take, push, pop, can_issue;

  // A completing read that coincides with a redirect is dropped.
  assign complete   = (state_q == REQ) && mem_ready && !redirect;
  assign head_valid = (count_q != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_vld = complete && !head_valid;
`else
  assign bypass_vld = 1'b0;
`endif

  assign bypass_take = bypass_vld && ir_accept;
  assign push        = complete && !bypass_take;
  assign pop         = head_valid && ir_accept;

  // Space is reserved at issue time, so decide on next-cycle occupancy.
  assign can_issue = start && !halt && (count_d < CNT_W'(DEPTH));

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  always_comb begin
    ir       = '0;
    ir_pc    = '0;
    ir_valid = 1'b0;
    if (head_valid) begin
      ir       = slot_data_q[rd_ptr_q];
      ir_pc    = slot_pc_q[rd_ptr_q];
      ir_valid = 1'b1;
    end else if (bypass_vld) begin
      ir       = mem_rdata;
      ir_pc    = mem_addr_q;
      ir_valid = 1'b1;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) fetch_pc_d = redirect_pc;
    case (state_q)
      IDLE: begin
        if (can_issue) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_d;
        end
      end
      REQ: begin
        if (mem_ready) begin
          if (!redirect) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          if (can_issue) begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_d;
          end else begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end else if (redirect) begin
          // The request cannot be withdrawn; keep it up and drop its data.
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= ADDR_W'(RESET_PC);
      fetch_pc_q <= ADDR_W'(RESET_PC);
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage carries no reset; ir/ir_pc are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      slot_data_q[wr_ptr_q] <= mem_rdata;
      slot_pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic against an in-order
// program-stream model (consumed words must follow the program order, restarting at each redirect target).
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, halt, ir_accept, redirect;
  logic [6:0] redirect_pc;
  logic       mem_req, mem_ready;
  logic [6:0] mem_addr, ir_pc;
  logic [7:0] mem_rdata, ir;
  logic       ir_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0] pmem [128];
  int  mem_lat   = 1;
  bit  rand_lat  = 1'b0;
  bit  stray_ready = 1'b0;
  bit  busy      = 1'b0;
  int  lat_left  = 0;
  int  resp_cnt  = 0;

  logic [6:0] exp_pc = 7'd32;
  int  consumed = 0;
  bit  prev_pend = 1'b0;
  bit  prev_block = 1'b0;
  logic [6:0] prev_addr = '0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_accept(ir_accept),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; ir_accept = 1'b0;
    redirect = 1'b0; redirect_pc = '0; stray_ready = 1'b0; rand_lat = 1'b0;
    ticks(2);
  endtask

  // Memory-controller port model: answers each request after mem_lat cycles.
  always @(negedge clk) begin
    mem_ready = stray_ready;
    if (stray_ready) mem_rdata = 8'($urandom);
    if (!rst_n) begin
      busy = 1'b0;
    end else if (mem_req) begin
      if (!busy) begin
        busy = 1'b1;
        lat_left = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
      end
      lat_left--;
      if (lat_left == 0) begin
        mem_ready = 1'b1;
        mem_rdata = pmem[mem_addr];
        busy = 1'b0;
        resp_cnt++;
      end
    end
  end

  // Program-order model and request-protocol checks, sampled mid-cycle.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      exp_pc = 7'd32;
      prev_pend = 1'b0;
      prev_block = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("req_held", 32'(mem_req), 32'd1);
        chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
      end
      if (prev_block) chk("no_issue_when_halted", 32'(mem_req), 32'd0);
      if (ir_valid && ir_accept) begin
        chk("consume_pc", 32'(ir_pc), 32'(exp_pc));
        chk("consume_ir", 32'(ir), 32'(pmem[exp_pc]));
        exp_pc = exp_pc + 7'd1;
        consumed++;
      end
      if (redirect) exp_pc = redirect_pc;
      prev_pend  = mem_req && !mem_ready;
      prev_addr  = mem_addr;
      prev_block = (halt || !start) && (!mem_req || mem_ready);
    end
  end

  initial begin
    int r0;
    for (int i = 0; i < 128; i++) pmem[i] = 8'($urandom);
    pmem[32] = 8'h21; pmem[33] = 8'h22; pmem[34] = 8'h23;
    rst_n = 1'b1;
    mem_ready = 1'b0; mem_rdata = '0;
    #1;
    do_reset();

    // Reset values
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd32);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_ir_pc", 32'(ir_pc), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);

    // Sequential fetch, 1-cycle memory, always accepting
    rst_n = 1'b1; start = 1'b1; ir_accept = 1'b1; mem_lat = 1;
    tick();
    chk("t1_req", 32'(mem_req), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'd32);
    chk("t1_valid", 32'(ir_valid), 32'd0);
    tick();
    chk("t1_ir0", {ir_valid, 8'(ir_pc), ir}, {1'b1, 8'd32, 8'h21});
    chk("t1_addr1", 32'(mem_addr), 32'd33);
    tick();
    chk("t1_ir1", {ir_valid, 8'(ir_pc), ir}, {1'b1, 8'd33, 8'h22});
    tick();
    chk("t1_ir2", {ir_valid, 8'(ir_pc), ir}, {1'b1, 8'd34, 8'h23});
    start = 1'b0;
    ticks(3);
    do_reset();

    // Queue fills to DEPTH with no accepts, 3-cycle memory
    rst_n = 1'b1; start = 1'b1; mem_lat = 3;
    ticks(7);
    chk("t2_req_low", 32'(mem_req), 32'd0);
    chk("t2_head", {ir_valid, 8'(ir_pc), ir}, {1'b1, 8'd32, pmem[32]});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_req_stays_low", 32'(mem_req), 32'd0);
    end
    r0 = resp_cnt;
    ir_accept = 1'b1;
    tick();
    ir_accept = 1'b0;
    chk("t2_head_after_pop", 32'(ir_pc), 32'd33);
    chk("t2_reissue", {mem_req, 7'(mem_addr)}, {1'b1, 7'd34});
    ticks(4);
    chk("t2_req_low_again", 32'(mem_req), 32'd0);
    chk("t2_single_request", 32'(resp_cnt - r0), 32'd1);
    do_reset();

    // Redirect while the request for 33 is pending
    rst_n = 1'b1; start = 1'b1; mem_lat = 3;
    ticks(5);
    chk("t3_pending_addr", {mem_req, 7'(mem_addr)}, {1'b1, 7'd33});
    redirect = 1'b1; redirect_pc = 7'd5;
    tick();
    redirect = 1'b0;
    chk("t3_flushed", 32'(ir_valid), 32'd0);
    chk("t3_req_kept", {mem_req, 7'(mem_addr)}, {1'b1, 7'd33});
    tick();
    chk("t3_discard_done", {mem_req, ir_valid}, 2'b00);
    tick();
    chk("t3_new_req", {mem_req, 7'(mem_addr)}, {1'b1, 7'd5});
    ticks(2);
    chk("t3_no_stale", 32'(ir_valid), 32'd0);
    tick();
    chk("t3_target", {ir_valid, 8'(ir_pc), ir}, {1'b1, 8'd5, pmem[5]});
    do_reset();

    // Redirect coincident with mem_ready and ir_accept
    rst_n = 1'b1; start = 1'b1; ir_accept = 1'b1; mem_lat = 1;
    ticks(2);
    chk("t4_coincide", {ir_valid, mem_ready, 7'(ir_pc)}, {1'b1, 1'b1, 7'd32});
    redirect = 1'b1; redirect_pc = 7'd70;
    tick();
    redirect = 1'b0;
    chk("t4_flushed", 32'(ir_valid), 32'd0);
    chk("t4_req_target", {mem_req, 7'(mem_addr)}, {1'b1, 7'd70});
    tick();
    chk("t4_target", {ir_valid, 8'(ir_pc), ir}, {1'b1, 8'd70, pmem[70]});
    start = 1'b0;
    ticks(2);
    do_reset();

    // Address wrap 127 -> 0
    rst_n = 1'b1; start = 1'b1; ir_accept = 1'b1; mem_lat = 1;
    redirect = 1'b1; redirect_pc = 7'd127;
    tick();
    redirect = 1'b0;
    chk("t5_addr127", 32'(mem_addr), 32'd127);
    tick();
    chk("t5_ir127", {ir_valid, 8'(ir_pc)}, {1'b1, 8'd127});
    chk("t5_addr0", 32'(mem_addr), 32'd0);
    tick();
    chk("t5_ir0", {ir_valid, 8'(ir_pc)}, {1'b1, 8'd0});
    start = 1'b0;
    ticks(2);
    do_reset();

    // Halt mid-request, then asynchronous reset mid-request and a stray mem_ready
    rst_n = 1'b1; start = 1'b1; mem_lat = 3;
    tick();
    halt = 1'b1;
    chk("t6_req", {mem_req, 7'(mem_addr)}, {1'b1, 7'd32});
    ticks(3);
    chk("t6_completed", {mem_req, ir_valid, 7'(ir_pc)}, {1'b0, 1'b1, 7'd32});
    tick();
    ir_accept = 1'b1;
    tick();
    ir_accept = 1'b0;
    chk("t6_popped_while_halted", {mem_req, ir_valid}, 2'b00);
    halt = 1'b0;
    tick();
    chk("t6_resume", {mem_req, 7'(mem_addr)}, {1'b1, 7'd33});
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst", {mem_req, 7'(mem_addr), ir_valid}, {1'b0, 7'd32, 1'b0});
    start = 1'b0;
    ticks(2);
    rst_n = 1'b1; stray_ready = 1'b1;
    tick();
    stray_ready = 1'b0;
    tick();
    chk("t6_stray_ignored", {mem_req, ir_valid}, 2'b00);
    start = 1'b1; mem_lat = 1;
    tick();
    chk("t6_restart", {mem_req, 7'(mem_addr)}, {1'b1, 7'd32});
    tick();
    chk("t6_restart_ir", {ir_valid, 8'(ir_pc)}, {1'b1, 8'd32});
    do_reset();

    // Randomized traffic against the program-order model
    rst_n = 1'b1; rand_lat = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      start       = ($urandom_range(0, 15) != 0);
      halt        = ($urandom_range(0, 9) == 0);
      ir_accept   = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 7'($urandom_range(0, 127));
      tick();
    end
    redirect = 1'b0;
    chk("rand_progress", 32'(consumed > 300), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
